// File: rtl/xor_syndrome_pkg.sv
// rtl/xor_syndrome_pkg.sv - shared defaults and width helper for the XOR syndrome pipeline
package xor_syndrome_pkg;

  localparam int XS_WIDTH_DEF  = 11;
  localparam int XS_STAGES_DEF = 2;
  localparam int XS_CNT_W_DEF  = 16;

  // Bits needed to hold a popcount of w bits (0..w inclusive).
  function automatic int clog2_p1(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xor_pipe_slice.sv
// rtl/xor_pipe_slice.sv - one valid+data register slice with load enable
module xor_pipe_slice
  import xor_syndrome_pkg::*;
#(
  parameter int WIDTH = XS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Capture the upstream beat (or bubble) whenever this slot is allowed to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/xor_syndrome_pipe.sv
// rtl/xor_syndrome_pipe.sv - pipelined a^b syndrome with handshake, error count; popcount under XOR_SYND_WEIGHT_EN
module xor_syndrome_pipe
  import xor_syndrome_pkg::*;
#(
  parameter int WIDTH  = XS_WIDTH_DEF,
  parameter int STAGES = XS_STAGES_DEF,
  parameter int CNT_W  = XS_CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic                         nonzero,
  output logic [clog2_p1(WIDTH)-1:0]   weight,
  output logic [CNT_W-1:0]             err_count
);

  localparam int WW = clog2_p1(WIDTH);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES:0]   adv;

  // A slot may advance if it is empty or everything downstream of it advances.
  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = ~v[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (k == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = a ^ b;
    end else begin : g_next
      assign up_v = v[k-1];
      assign up_d = d[k-1];
    end
    xor_pipe_slice #(.WIDTH(WIDTH)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .load     (adv[k]),
      .in_valid (up_v),
      .in_data  (up_d),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out       = d[STAGES-1];
  assign nonzero   = out_valid & (|out);

`ifdef XOR_SYND_WEIGHT_EN
  // Popcount of the presented syndrome, forced to zero while no beat is presented.
  always_comb begin
    weight = '0;
    if (out_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        weight = weight + WW'(out[i]);
      end
    end
  end
`else
  assign weight = '0;
`endif

  // Count delivered non-zero syndromes, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && nonzero && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_xor_syndrome_pipe.sv
// tb/tb_xor_syndrome_pipe.sv - scoreboard bench for xor_syndrome_pipe
module tb_xor_syndrome_pipe;

  localparam int W  = 11;
  localparam int S  = 2;
  localparam int CW = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out;
  logic          nonzero;
  logic [WW-1:0] weight;
  logic [CW-1:0] err_count;

  xor_syndrome_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .nonzero   (nonzero),
    .weight    (weight),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [$];
  int model_cnt = 0;
  int rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_weight(input logic [W-1:0] s);
`ifdef XOR_SYND_WEIGHT_EN
    return $countones(s);
`else
    return 0;
`endif
  endfunction

  // Downstream ready generator, applied just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: checks stall stability and pops the scoreboard on every output transfer.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(out), 64'(prev_out));
      end
      if (!out_valid) begin
        chk("idle_nonzero", 64'(nonzero), 64'd0);
        chk("idle_weight", 64'(weight), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(out), 64'h1_0000_0000);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("out", 64'(out), 64'(e));
          chk("nonzero", 64'(nonzero), 64'(e != 0));
          chk("weight", 64'(weight), 64'(exp_weight(e)));
          chk("err_count", 64'(err_count), 64'(model_cnt));
          if (e != 0 && model_cnt < (1 << CW) - 1) model_cnt++;
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = out;
    end
  end

  // Offer one beat until accepted; the expected syndrome is queued at acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit done = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(x ^ y);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [W-1:0] beats [4];
  int idx;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_nonzero", 64'(nonzero), 64'd0);
    chk("rst_weight", 64'(weight), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Latency of exactly two cycles
    send(11'h5A5, 11'h0F0);
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_out", 64'(out), 64'h555);
    chk("lat_nonzero", 64'(nonzero), 64'd1);
    @(posedge clk);
    #1;
    chk("lat_err_count", 64'(err_count), 64'd1);

    // Zero syndrome leaves the count alone
    send(11'h3FF, 11'h3FF);
    drain();
    idle(2);
    chk("zero_err_count", 64'(err_count), 64'd1);

    // Backpressure: only two beats fit while stalled
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < 4; i++) beats[i] = W'($urandom);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a = beats[idx];
      b = 11'h00F;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(beats[idx] ^ 11'h00F);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(out), 64'(beats[0] ^ 11'h00F));
    rdy_mode = 0;
    for (int i = idx; i < 4; i++) send(beats[i], 11'h00F);
    drain();

    // Weight of an all-ones syndrome
    send(11'h7FF, 11'h000);
    drain();

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] x;
      x = W'($urandom);
      send(x, x ^ W'($urandom_range(1, 2047)));
    end
    drain();
    idle(2);
    chk("sat_err_count", 64'(err_count), 64'hF);

    // Asynchronous reset with beats in flight
    rdy_mode = 1;
    idle(2);
    send(11'h123, 11'h456);
    send(11'h321, 11'h654);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      if ($urandom_range(0, 3) == 0) idle(1);
      x = W'($urandom);
      y = ($urandom_range(0, 4) == 0) ? x : W'($urandom);
      send(x, y);
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
